// File: rtl/vga_plot_capture.sv
// VGA plot-interface sink: captures plotted pixels into a WIDTH x HEIGHT frame store,
// keeps plot/out-of-range counts and a bounding box, and serves 1-cycle-latency reads.
module vga_plot_capture #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int CW     = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    vga_x,
    input  logic [6:0]    vga_y,
    input  logic [CW-1:0] vga_colour,
    input  logic          vga_plot,
    input  logic          clear,
    output logic          clear_busy,
    input  logic          rd_en,
    input  logic [7:0]    rd_x,
    input  logic [6:0]    rd_y,
    output logic [CW-1:0] rd_colour,
    output logic          rd_valid,
    output logic [14:0]   plot_count,
    output logic [7:0]    oob_count,
    output logic          bbox_valid,
    output logic [7:0]    min_x,
    output logic [7:0]    max_x,
    output logic [6:0]    min_y,
    output logic [6:0]    max_y
);

    localparam int          DEPTH     = WIDTH * HEIGHT;
    localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);
    localparam logic [7:0]  WIDTH_X   = 8'(WIDTH);
    localparam logic [6:0]  HEIGHT_Y  = 7'(HEIGHT);
    localparam logic [14:0] PLOT_MAX  = 15'h7FFF;
    localparam logic [7:0]  OOB_MAX   = 8'hFF;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
        return 15'(y) * 15'(WIDTH) + 15'(x);
    endfunction

    logic [CW-1:0] mem [0:DEPTH-1];

    state_t        state_q, state_d;
    logic [14:0]   clr_addr_q, clr_addr_d;
    logic [14:0]   plot_count_q, plot_count_d;
    logic [7:0]    oob_count_q, oob_count_d;
    logic          bbox_valid_q, bbox_valid_d;
    logic [7:0]    min_x_q, min_x_d, max_x_q, max_x_d;
    logic [6:0]    min_y_q, min_y_d, max_y_q, max_y_d;
    logic          clear_busy_q, clear_busy_d;
    logic [CW-1:0] rd_colour_q;
    logic          rd_valid_q;

    logic          plot_in_range_s;
    logic          rd_in_range_s;
    logic          we_s;
    logic          we_en_s;
    logic [14:0]   waddr_s;
    logic [CW-1:0] wdata_s;

    assign plot_in_range_s = (vga_x < WIDTH_X) && (vga_y < HEIGHT_Y);
    assign rd_in_range_s   = (rd_x < WIDTH_X) && (rd_y < HEIGHT_Y);
    // Reset aborts any in-flight store write, including a clear sweep step.
    assign we_en_s         = we_s && !rst;

    // Next-state, statistics and frame-store write-port selection.
    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        plot_count_d = plot_count_q;
        oob_count_d  = oob_count_q;
        bbox_valid_d = bbox_valid_q;
        min_x_d      = min_x_q;
        max_x_d      = max_x_q;
        min_y_d      = min_y_q;
        max_y_d      = max_y_q;
        we_s         = 1'b0;
        waddr_s      = pix_addr(vga_x, vga_y);
        wdata_s      = vga_colour;

        case (state_q)
            S_IDLE: begin
                // clear takes priority over a plot offered in the same cycle
                if (clear) begin
                    state_d      = S_CLEAR;
                    clr_addr_d   = 15'd0;
                    plot_count_d = 15'd0;
                    oob_count_d  = 8'd0;
                    bbox_valid_d = 1'b0;
                end else if (vga_plot && plot_in_range_s) begin
                    we_s         = 1'b1;
                    plot_count_d = (plot_count_q != PLOT_MAX) ? plot_count_q + 15'd1 : plot_count_q;
                    bbox_valid_d = 1'b1;
                    if (!bbox_valid_q) begin
                        min_x_d = vga_x;
                        max_x_d = vga_x;
                        min_y_d = vga_y;
                        max_y_d = vga_y;
                    end else begin
                        min_x_d = (vga_x < min_x_q) ? vga_x : min_x_q;
                        max_x_d = (vga_x > max_x_q) ? vga_x : max_x_q;
                        min_y_d = (vga_y < min_y_q) ? vga_y : min_y_q;
                        max_y_d = (vga_y > max_y_q) ? vga_y : max_y_q;
                    end
                end else if (vga_plot) begin
                    oob_count_d = (oob_count_q != OOB_MAX) ? oob_count_q + 8'd1 : oob_count_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                we_s    = 1'b1;
                waddr_s = clr_addr_q;
                wdata_s = '0;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = S_IDLE;
                    clr_addr_d = 15'd0;
                end else begin
                    clr_addr_d = clr_addr_q + 15'd1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                clr_addr_d = 15'd0;
            end
        endcase

        clear_busy_d = (state_d == S_CLEAR);
    end

    // State, sweep counter and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            clr_addr_q   <= 15'd0;
            plot_count_q <= 15'd0;
            oob_count_q  <= 8'd0;
            bbox_valid_q <= 1'b0;
            min_x_q      <= 8'd0;
            max_x_q      <= 8'd0;
            min_y_q      <= 7'd0;
            max_y_q      <= 7'd0;
            clear_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            plot_count_q <= plot_count_d;
            oob_count_q  <= oob_count_d;
            bbox_valid_q <= bbox_valid_d;
            min_x_q      <= min_x_d;
            max_x_q      <= max_x_d;
            min_y_q      <= min_y_d;
            max_y_q      <= max_y_d;
            clear_busy_q <= clear_busy_d;
        end
    end

    // Frame-store write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_en_s) begin
            mem[waddr_s] <= wdata_s;
        end
    end

    // Read port: read-first, so a same-cycle write to the address returns the old colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q  <= 1'b0;
            rd_colour_q <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_colour_q <= rd_in_range_s ? mem[pix_addr(rd_x, rd_y)] : '0;
            end
        end
    end

    assign clear_busy = clear_busy_q;
    assign rd_colour  = rd_colour_q;
    assign rd_valid   = rd_valid_q;
    assign plot_count = plot_count_q;
    assign oob_count  = oob_count_q;
    assign bbox_valid = bbox_valid_q;
    assign min_x      = min_x_q;
    assign max_x      = max_x_q;
    assign min_y      = min_y_q;
    assign max_y      = max_y_q;

endmodule

// File: tb/tb_vga_plot_capture.sv
// Directed self-checking bench for vga_plot_capture.
module tb_vga_plot_capture;

    logic       clk = 1'b0;
    logic       rst, vga_plot, clear, rd_en;
    logic [7:0] vga_x, rd_x;
    logic [6:0] vga_y, rd_y;
    logic [2:0] vga_colour;
    logic       clear_busy, rd_valid, bbox_valid;
    logic [2:0] rd_colour;
    logic [14:0] plot_count;
    logic [7:0] oob_count, min_x, max_x;
    logic [6:0] min_y, max_y;

    int checks = 0;
    int fails  = 0;

    vga_plot_capture #(.WIDTH(160), .HEIGHT(120), .CW(3)) dut (
        .clk(clk), .rst(rst), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .clear(clear), .clear_busy(clear_busy), .rd_en(rd_en),
        .rd_x(rd_x), .rd_y(rd_y), .rd_colour(rd_colour), .rd_valid(rd_valid),
        .plot_count(plot_count), .oob_count(oob_count), .bbox_valid(bbox_valid),
        .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        vga_x = x; vga_y = y; vga_colour = c; vga_plot = 1'b1;
        tick();
        vga_plot = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [7:0] x, input logic [6:0] y, input logic [2:0] exp_c);
        rd_x = x; rd_y = y; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_colour !== exp_c) begin
            fails++;
            $display("FAIL %s: got valid=%0b colour=%0d, expected valid=1 colour=%0d", name, rd_valid, rd_colour, exp_c);
        end
    endtask

    task automatic wait_clear_done(input int already, input string name);
        int n = already;
        while (clear_busy === 1'b1 && n < 30000) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 19200) begin fails++; $display("FAIL %s: busy cycles got %0d expected 19200", name, n); end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        checks++;
        if ({clear_busy, rd_valid, rd_colour, bbox_valid} !== 6'd0) begin
            fails++; $display("FAIL reset_flags: got busy=%0b valid=%0b colour=%0d bbox=%0b expected all 0", clear_busy, rd_valid, rd_colour, bbox_valid);
        end
        checks++;
        if (plot_count !== 15'd0 || oob_count !== 8'd0) begin
            fails++; $display("FAIL reset_counts: got plot=%0d oob=%0d expected 0 0", plot_count, oob_count);
        end
        checks++;
        if ({min_x, max_x, min_y, max_y} !== 30'd0) begin
            fails++; $display("FAIL reset_bbox: got %0d %0d %0d %0d expected 0", min_x, max_x, min_y, max_y);
        end
    endtask

    task automatic test_clear();
        clear = 1'b1; tick(); clear = 1'b0;
        checks++;
        if (clear_busy !== 1'b1) begin fails++; $display("FAIL clear_busy_rise: got %0b expected 1", clear_busy); end
        wait_clear_done(0, "clear_len");
        read_chk("clear_rd_0_0", 8'd0, 7'd0, 3'd0);
        read_chk("clear_rd_159_119", 8'd159, 7'd119, 3'd0);
        checks++;
        if (plot_count !== 15'd0 || oob_count !== 8'd0 || bbox_valid !== 1'b0) begin
            fails++; $display("FAIL clear_counts: got plot=%0d oob=%0d bbox=%0b expected 0", plot_count, oob_count, bbox_valid);
        end
        checks++;
        if (rd_valid !== 1'b0) begin
            tick();
        end
        tick();
        if (rd_valid !== 1'b0) begin fails++; $display("FAIL rd_valid_drop: got %0b expected 0", rd_valid); end
    endtask

    task automatic test_plot();
        do_plot(8'd10, 7'd20, 3'd5);
        read_chk("plot_rd", 8'd10, 7'd20, 3'd5);
        checks++;
        if (plot_count !== 15'd1 || bbox_valid !== 1'b1 || min_x !== 8'd10 || max_x !== 8'd10 || min_y !== 7'd20 || max_y !== 7'd20) begin
            fails++; $display("FAIL plot_stats: got cnt=%0d bv=%0b x=%0d..%0d y=%0d..%0d expected 1 1 10..10 20..20", plot_count, bbox_valid, min_x, max_x, min_y, max_y);
        end
    endtask

    task automatic test_multi();
        do_plot(8'd3, 7'd100, 3'd1);
        do_plot(8'd150, 7'd7, 3'd2);
        do_plot(8'd3, 7'd100, 3'd6);
        checks++;
        if (plot_count !== 15'd4 || min_x !== 8'd3 || max_x !== 8'd150 || min_y !== 7'd7 || max_y !== 7'd100) begin
            fails++; $display("FAIL multi_stats: got cnt=%0d x=%0d..%0d y=%0d..%0d expected 4 3..150 7..100", plot_count, min_x, max_x, min_y, max_y);
        end
        read_chk("multi_rd_3_100", 8'd3, 7'd100, 3'd6);
        read_chk("multi_rd_150_7", 8'd150, 7'd7, 3'd2);
    endtask

    task automatic test_oob();
        do_plot(8'd160, 7'd0, 3'd7);
        do_plot(8'd0, 7'd120, 3'd7);
        do_plot(8'd255, 7'd127, 3'd7);
        checks++;
        if (oob_count !== 8'd3 || plot_count !== 15'd4 || max_x !== 8'd150 || max_y !== 7'd100) begin
            fails++; $display("FAIL oob_stats: got oob=%0d cnt=%0d maxx=%0d maxy=%0d expected 3 4 150 100", oob_count, plot_count, max_x, max_y);
        end
        read_chk("oob_alias_0_1", 8'd0, 7'd1, 3'd0);
        read_chk("oob_rd_160_0", 8'd160, 7'd0, 3'd0);
        read_chk("oob_rd_0_120", 8'd0, 7'd120, 3'd0);
    endtask

    task automatic test_read_first();
        vga_x = 8'd10; vga_y = 7'd20; vga_colour = 3'd3; vga_plot = 1'b1;
        rd_x = 8'd10; rd_y = 7'd20; rd_en = 1'b1;
        tick();
        vga_plot = 1'b0; rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_colour !== 3'd5) begin
            fails++; $display("FAIL read_first: got valid=%0b colour=%0d expected 1 5", rd_valid, rd_colour);
        end
        read_chk("read_after_write", 8'd10, 7'd20, 3'd3);
        checks++;
        if (plot_count !== 15'd5) begin fails++; $display("FAIL replot_count: got %0d expected 5", plot_count); end
    endtask

    task automatic test_clear_collision();
        int k;
        clear = 1'b1; vga_x = 8'd50; vga_y = 7'd50; vga_colour = 3'd7; vga_plot = 1'b1;
        tick();
        clear = 1'b0; vga_plot = 1'b0;
        checks++;
        if (clear_busy !== 1'b1 || plot_count !== 15'd0 || oob_count !== 8'd0 || bbox_valid !== 1'b0) begin
            fails++; $display("FAIL clear_vs_plot: got busy=%0b cnt=%0d oob=%0d bv=%0b expected 1 0 0 0", clear_busy, plot_count, oob_count, bbox_valid);
        end
        k = 0;
        // pixel (3,100) is address 16003, far ahead of the sweep: still holds colour 6
        read_chk("rd_during_clear", 8'd3, 7'd100, 3'd6); k++;
        do_plot(8'd1, 7'd1, 3'd7); k++;
        do_plot(8'd200, 7'd0, 3'd7); k++;
        clear = 1'b1; tick(); clear = 1'b0; k++;
        checks++;
        if (plot_count !== 15'd0 || oob_count !== 8'd0 || bbox_valid !== 1'b0) begin
            fails++; $display("FAIL plot_during_clear: got cnt=%0d oob=%0d bv=%0b expected 0 0 0", plot_count, oob_count, bbox_valid);
        end
        wait_clear_done(k, "reclear_ignored_len");
        read_chk("collide_rd_50_50", 8'd50, 7'd50, 3'd0);
        read_chk("collide_rd_3_100", 8'd3, 7'd100, 3'd0);
    endtask

    task automatic test_fill();
        vga_colour = 3'd4; vga_plot = 1'b1;
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                vga_x = 8'(x); vga_y = 7'(y);
                tick();
            end
        end
        vga_plot = 1'b0;
        checks++;
        if (plot_count !== 15'd19200 || min_x !== 8'd0 || max_x !== 8'd159 || min_y !== 7'd0 || max_y !== 7'd119) begin
            fails++; $display("FAIL fill_stats: got cnt=%0d x=%0d..%0d y=%0d..%0d expected 19200 0..159 0..119", plot_count, min_x, max_x, min_y, max_y);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_x = 8'(i * 53); rd_y = 7'(i * 39);
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_colour !== 3'd4) begin
                fails++; $display("FAIL fill_b2b_rd%0d: got valid=%0b colour=%0d expected 1 4", i, rd_valid, rd_colour);
            end
        end
        rd_en = 1'b0;
        vga_x = 8'd5; vga_y = 7'd5; vga_plot = 1'b1;
        for (int i = 0; i < 13568; i++) tick();
        vga_plot = 1'b0;
        checks++;
        if (plot_count !== 15'd32767) begin fails++; $display("FAIL plot_sat: got %0d expected 32767", plot_count); end
        vga_plot = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        vga_plot = 1'b0;
        checks++;
        if (plot_count !== 15'd32767) begin fails++; $display("FAIL plot_sat_hold: got %0d expected 32767", plot_count); end
        vga_x = 8'd170; vga_y = 7'd0; vga_plot = 1'b1;
        for (int i = 0; i < 260; i++) tick();
        vga_plot = 1'b0;
        checks++;
        if (oob_count !== 8'd255 || plot_count !== 15'd32767) begin
            fails++; $display("FAIL oob_sat: got oob=%0d cnt=%0d expected 255 32767", oob_count, plot_count);
        end
    endtask

    task automatic test_reset_mid_clear();
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        checks++;
        if (clear_busy !== 1'b1) begin fails++; $display("FAIL mid_clear_busy: got %0b expected 1", clear_busy); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (clear_busy !== 1'b0 || plot_count !== 15'd0 || oob_count !== 8'd0) begin
            fails++; $display("FAIL rst_mid_clear: got busy=%0b cnt=%0d oob=%0d expected 0 0 0", clear_busy, plot_count, oob_count);
        end
        // (0,0) was swept, (100,100) was not: store holds partial contents
        read_chk("partial_rd_0_0", 8'd0, 7'd0, 3'd0);
        read_chk("partial_rd_100_100", 8'd100, 7'd100, 3'd4);
        do_plot(8'd2, 7'd2, 3'd1);
        checks++;
        if (plot_count !== 15'd1 || bbox_valid !== 1'b1 || min_x !== 8'd2 || max_y !== 7'd2) begin
            fails++; $display("FAIL post_rst_plot: got cnt=%0d bv=%0b minx=%0d maxy=%0d expected 1 1 2 2", plot_count, bbox_valid, min_x, max_y);
        end
    endtask

    initial begin
        rst = 1'b0; vga_plot = 1'b0; clear = 1'b0; rd_en = 1'b0;
        vga_x = 8'd0; vga_y = 7'd0; vga_colour = 3'd0; rd_x = 8'd0; rd_y = 7'd0;
        #2;
        test_reset();
        test_clear();
        test_plot();
        test_multi();
        test_oob();
        test_read_first();
        test_clear_collision();
        test_fill();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
